// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle fetch/decode/issue controller for the RISC-16 ALU
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req/imem_addr/imem_ack/imem_rdata  instruction fetch handshake
//   alu_rx/alu_ry/alu_op               registered operands and opcode to the ALU
//   alu_out/alu_carry/alu_zero/alu_parity  ALU result and flags
//   flags                              {carry,zero,parity} of the last ALU instruction
//   pc, halted                         program counter, HALT executed
//   dbg_addr/dbg_data                  combinational register file read port
// Build option: define REG0_ZERO_EN to hard-wire R0 to zero.
module alu_issue_ctrl #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [DATA_W-1:0] alu_rx,
    output logic [DATA_W-1:0] alu_ry,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_parity,
    output logic [2:0]        flags,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
`ifdef REG0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] rx_q, rx_d, ry_q, ry_d, result_q, result_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        flags_q, flags_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];
    logic [3:0]        op, x, y;
    logic              is_alu, is_ldi;
    assign op     = ir_q[15:12];
    assign x      = ir_q[11:8];
    assign y      = ir_q[7:4];
    assign is_alu = (op != 4'h0) && (op < 4'hE);
    assign is_ldi = (op == 4'hE);
    function automatic logic [DATA_W-1:0] rf_rd(input logic [3:0] i);
        return (R0_ZERO && i == 4'd0) ? '0 : rf_q[i];
    endfunction
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        halted_d = halted_q;
        rf_d     = rf_q;
        case (state_q)
            FETCH: begin
                // an ack only counts while our request is actually up
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                rx_d    = rf_rd(x);
                ry_d    = rf_rd(y);
                op_d    = is_alu ? op : op_q;
                state_d = EXEC;
            end
            EXEC: begin
                if (op == 4'hF) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    result_d = is_alu ? alu_out : result_q;
                    flags_d  = is_alu ? {alu_carry, alu_zero, alu_parity} : flags_q;
                    state_d  = WB;
                end
            end
            WB: begin
                if ((is_alu || is_ldi) && !(R0_ZERO && x == 4'd0))
                    rf_d[x] = is_alu ? result_q : DATA_W'(ir_q[7:0]);
                pc_d    = pc_q + PC_W'(1);
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
        // registered so the first request appears one cycle after reset release
        req_d = (state_d == FETCH);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= PC_W'(RESET_PC);
            ir_q     <= '0;
            req_q    <= 1'b0;
            rx_q     <= '0;
            ry_q     <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            halted_q <= 1'b0;
            rf_q     <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            halted_q <= halted_d;
            rf_q     <= rf_d;
        end
    end
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign alu_rx    = rx_q;
    assign alu_ry    = ry_q;
    assign alu_op    = op_q;
    assign flags     = flags_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign dbg_data  = rf_rd(dbg_addr);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with an ALU and imem model
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] alu_rx, alu_ry, alu_out, dbg_data;
    logic [3:0]  alu_op, dbg_addr;
    logic        alu_carry, alu_zero, alu_parity, halted;
    logic [2:0]  flags;
    logic [7:0]  pc;
    logic [15:0] imem [256];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    always #5 clk = ~clk;
    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .alu_rx(alu_rx), .alu_ry(alu_ry), .alu_op(alu_op),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_parity(alu_parity),
        .flags(flags), .pc(pc), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );
    assign imem_ack   = imem_req && (wait_cnt == ack_delay);
    assign imem_rdata = imem[imem_addr];
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end
    logic [16:0] wide;
    logic [31:0] prod;
    always_comb begin
        prod = {16'h0, alu_rx} * {16'h0, alu_ry};
        wide = (alu_op == 4'h1) ? {1'b0, alu_rx} + {1'b0, alu_ry} :
               (alu_op == 4'h2) ? {1'b0, alu_rx} - {1'b0, alu_ry} :
               (alu_op == 4'h3) ? {|prod[31:16], prod[15:0]} :
               (alu_op == 4'h4) ? {1'b0, alu_rx & alu_ry} :
               (alu_op == 4'h5) ? {1'b0, alu_rx | alu_ry} : {1'b0, alu_rx ^ alu_ry};
        alu_out    = wide[15:0];
        alu_carry  = wide[16];
        alu_zero   = (wide[15:0] == 16'h0);
        alu_parity = ~^wide[15:0];
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic load(input logic [0:7][15:0] prog, input int delay);
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) imem[i] = prog[i];
        ack_delay = delay;
    endtask
    task automatic restart();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic run_to_halt();
        int n = 0;
        while (!halted && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask
    task automatic wait_fetch(input logic [7:0] a, input int limit);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("fetch_seen", 32'(imem_req && imem_addr == a), 32'd1);
    endtask
    task automatic read_reg(input logic [3:0] r, output logic [15:0] v);
        dbg_addr = r;
        #1;
        v = dbg_data;
    endtask
    typedef struct {
        string           name;
        logic [0:7][15:0] prog;
        logic [3:0]      ridx;
        logic [15:0]     rval;
        logic [2:0]      flg;
        logic [7:0]      pcv;
    } vec_t;
    vec_t vecs [6];
    initial begin
        logic [15:0] v;
        int t0, held;
        dbg_addr = 4'd0;
        vecs[0] = '{"add",    {16'hE105, 16'hE203, 16'h1120, 16'hF000, 64'h0}, 4'd1, 16'h0008, 3'b000, 8'd3};
        vecs[1] = '{"mul",    {16'hE105, 16'hE203, 16'h3120, 16'hF000, 64'h0}, 4'd1, 16'h000F, 3'b001, 8'd3};
        vecs[2] = '{"sub_nop",{16'hE105, 16'hE205, 16'h2120, 16'h0000, 16'hF000, 48'h0}, 4'd1, 16'h0000, 3'b011, 8'd4};
        vecs[3] = '{"x_eq_y", {16'hE107, 16'h1110, 16'hF000, 80'h0}, 4'd1, 16'h000E, 3'b000, 8'd2};
        vecs[4] = '{"carry",  {16'hE1FF, 16'h3110, 16'h1110, 16'hF000, 64'h0}, 4'd1, 16'hFC02, 3'b100, 8'd3};
`ifdef REG0_ZERO_EN
        vecs[5] = '{"ldi_r0", {16'hE0AA, 16'hF000, 96'h0}, 4'd0, 16'h0000, 3'b000, 8'd1};
`else
        vecs[5] = '{"ldi_r0", {16'hE0AA, 16'hF000, 96'h0}, 4'd0, 16'h00AA, 3'b000, 8'd1};
`endif
        load({16'hE105, 16'hF000, 96'h0}, 0);
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        #1;
        check("req_at_release", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("req_after_release", 32'(imem_req), 32'd1);
        for (int i = 0; i < 6; i++) begin
            load(vecs[i].prog, 0);
            restart();
            run_to_halt();
            read_reg(vecs[i].ridx, v);
            check({vecs[i].name, "_reg"}, 32'(v), 32'(vecs[i].rval));
            check({vecs[i].name, "_flags"}, 32'(flags), 32'(vecs[i].flg));
            check({vecs[i].name, "_pc"}, 32'(pc), 32'(vecs[i].pcv));
        end
        for (int d = 0; d <= 3; d += 3) begin
            load({16'h0000, 16'h0000, 16'h0000, 16'hF000, 64'h0}, d);
            restart();
            wait_fetch(8'd0, 10);
            t0 = cyc;
            held = 0;
            while (imem_req && imem_addr == 8'd0 && held < 20) begin
                @(negedge clk);
                held++;
            end
            check("req_hold_cycles", 32'(held), 32'(d + 1));
            wait_fetch(8'd1, 20);
            check("instr_latency", 32'(cyc - t0), 32'(d + 4));
            run_to_halt();
            check("halt_pc", 32'(pc), 32'd3);
            held = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                held += int'(imem_req);
            end
            check("halt_no_req", 32'(held), 32'd0);
            check("halt_pc_stays", 32'(pc), 32'd3);
        end
        load({16'h0000, 112'h0}, 0);
        restart();
        wait_fetch(8'd255, 1300);
        @(negedge clk);
        wait_fetch(8'd0, 10);
        check("wrap_addr", 32'(imem_addr), 32'd0);
        load({16'hE203, 16'h1120, 16'hF000, 80'h0}, 0);
        restart();
        wait_fetch(8'd1, 20);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_req", 32'(imem_req), 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        read_reg(4'd1, v);
        check("abort_r1", 32'(v), 32'd0);
        read_reg(4'd2, v);
        check("abort_r2", 32'(v), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_req_held", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        run_to_halt();
        read_reg(4'd1, v);
        check("rerun_r1", 32'(v), 32'd3);
        check("rerun_pc", 32'(pc), 32'd2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
